// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ITER = 2'b01,
    S_FIN  = 2'b10
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation: absolute value of operands and sign
// correction of results.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring) unit
// with HI/LO result registers and a divide-by-zero flag.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             lo_neg_q, lo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  op_e              op_in;
  logic             sgn_in, div_in;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign op_in  = op_e'(op);
  assign sgn_in = op_is_signed(op_in);
  assign div_in = op_is_div(op_in);

  mdu_sign_fix #(.W(WIDTH)) u_abs_a (.val(a), .neg(sgn_in & a[WIDTH-1]), .res(abs_a));
  mdu_sign_fix #(.W(WIDTH)) u_abs_b (.val(b), .neg(sgn_in & b[WIDTH-1]), .res(abs_b));

  mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .val({acc_q[WIDTH-1:0], shreg_q}), .neg(lo_neg_q), .res(prod_fix)
  );
  mdu_sign_fix #(.W(WIDTH)) u_fix_quo (.val(shreg_q), .neg(lo_neg_q), .res(quo_fix));
  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (.val(acc_q[WIDTH-1:0]), .neg(rem_neg_q), .res(rem_fix));

  // Multiply: acc holds the running upper half, shreg the multiplier shifting out.
  // Divide: acc holds the partial remainder, shreg the dividend shifting into quotient.
  assign mul_sum   = {1'b0, acc_q[WIDTH-1:0]} + (shreg_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q[WIDTH-1:0], shreg_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  // NOTE: every signal gets a default at the top so no path leaves it unassigned,
  // which is what keeps this block from inferring latches.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    lo_neg_d   = lo_neg_q;
    rem_neg_d  = rem_neg_q;
    dz_d       = dz_q;
    acc_d      = acc_q;
    shreg_d    = shreg_q;
    opnd_d     = opnd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d   = div_in;
          lo_neg_d   = sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
          rem_neg_d  = sgn_in & a[WIDTH-1];
          dz_d       = div_in && (b == '0);
          acc_d      = '0;
          shreg_d    = div_in ? abs_a : abs_b;
          opnd_d     = div_in ? abs_b : abs_a;
          cnt_d      = '0;
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          state_d    = (div_in && (b == '0)) ? S_FIN : S_ITER;
        end
      end
      S_ITER: begin
        if (is_div_q) begin
          if (!div_trial[WIDTH]) begin
            acc_d   = div_trial;
            shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d   = div_shift;
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d   = {1'b0, mul_sum[WIDTH:1]};
          shreg_d = {mul_sum[0], shreg_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      lo_neg_q   <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_q       <= 1'b0;
      acc_q      <= '0;
      shreg_q    <= '0;
      opnd_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      lo_neg_q   <= lo_neg_d;
      rem_neg_q  <= rem_neg_d;
      dz_q       <= dz_d;
      acc_q      <= acc_d;
      shreg_q    <= shreg_d;
      opnd_q     <= opnd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int tests  = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Caller is positioned at a negedge (cycle 0). Returns at the negedge of the
  // done cycle. extra_at >= 1 pulses start again in that cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input int lat, input int extra_at);
    int   cyc;
    logic busy_bad;
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = 32'h1234_5678; b = 32'h0000_0003;
    cyc = 1; busy_bad = 1'b0;
    check({tag, "_dz_clr_c1"}, {63'd0, div_zero}, 64'd0);
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      start = (cyc == extra_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_busy_win"}, {63'd0, busy_bad}, 64'd0);
    check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
    check({tag, "_dz"}, {63'd0, div_zero}, {63'd0, edz});
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dz", {63'd0, div_zero}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, -1);
    @(negedge clk);
    check("mult_neg_done_1cyc", {63'd0, done}, 64'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, -1);
    @(negedge clk);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, -1);
    @(negedge clk);
    run_op("div_negdiv", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34, -1);
    @(negedge clk);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, -1);
    @(negedge clk);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'd2, 32'd14, 1'b1, 2, -1);
    @(negedge clk);
    check("dz_held", {63'd0, div_zero}, 64'd1);
    run_op("mult_after_dz", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, 34, -1);
    @(negedge clk);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34, -1);
    @(negedge clk);

    run_op("mult_extra", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 34, 5);
    count_dones(40, n);
    check("mult_extra_no_queue", 64'(n), 64'd0);

    // Start issued in the done cycle itself must be accepted.
    @(negedge clk);
    run_op("b2b_first", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, -1);
    run_op("b2b_second", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34, -1);

    // Reset in cycle 10 of a multiply aborts it.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_c10", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy_c11", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    count_dones(40, n);
    check("abort_no_done", 64'(n), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
